// File: rtl/moving_avg_dcr.sv
// Per-channel moving average / DC removal over a 2**LOG2_DEPTH sample window held in register arrays.
// Latency one cycle from an accepted sample to registered data_o with a single-cycle valid_o pulse.
module moving_avg_dcr #(
  parameter int DW         = 32,
  parameter int LOG2_DEPTH = 7,
  parameter int CH         = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               valid_i,
  input  logic               clear_i,
  input  logic [1:0]         mode_i,
  input  logic [CH*DW-1:0]   data_i,
  output logic [CH*DW-1:0]   data_o,
  output logic               valid_o,
  output logic               primed_o,
  output logic [CH-1:0]      sat_o
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int AW    = DW + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   FULL    = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   ONE_F   = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH-1:0] ONE_P   = LOG2_DEPTH'(1);
  localparam logic [DW-1:0]         MAX_V   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]         MIN_V   = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0]  r_buf [CH][DEPTH];
  logic signed [AW-1:0]  r_sum [CH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_DEPTH:0]   r_fill;
  logic [CH*DW-1:0]      r_data;
  logic                  r_valid;
  logic                  r_primed;
  logic [CH-1:0]         r_sat;

  logic                  w_accept;
  logic [LOG2_DEPTH:0]   w_fill_nxt;
  logic signed [DW-1:0]  w_x       [CH];
  logic signed [AW-1:0]  w_sum_new [CH];
  logic signed [DW-1:0]  w_mean    [CH];
  logic [DW:0]           w_dcr     [CH];
  logic [DW-1:0]         w_res     [CH];
  logic [CH-1:0]         w_sat;

  assign w_accept   = start_i & valid_i;
  assign w_fill_nxt = (r_fill == FULL) ? r_fill : r_fill + ONE_F;

  always_comb begin
    w_sat = '0;
    for (int k = 0; k < CH; k++) begin
      w_x[k]       = data_i[k*DW +: DW];
      w_sum_new[k] = r_sum[k] + AW'(w_x[k]) - AW'(r_buf[k][r_wr_ptr]);
      // Mean always fits DW bits, so the truncation only drops sign copies.
      w_mean[k]    = DW'(w_sum_new[k] >>> LOG2_DEPTH);
      w_dcr[k]     = {w_x[k][DW-1], w_x[k]} - {w_mean[k][DW-1], w_mean[k]};
      w_res[k]     = w_x[k];
      case (mode_i)
        2'b00: w_res[k] = w_x[k];
        2'b10: w_res[k] = w_mean[k];
        default: begin
          if (w_dcr[k][DW] != w_dcr[k][DW-1]) begin
            w_res[k] = w_dcr[k][DW] ? MIN_V : MAX_V;
            w_sat[k] = 1'b1;
          end else begin
            w_res[k] = w_dcr[k][DW-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      for (int k = 0; k < CH; k++) begin
        for (int d = 0; d < DEPTH; d++) begin
          r_buf[k][d] <= '0;
        end
        r_sum[k] <= '0;
      end
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_primed <= 1'b0;
      r_sat    <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        for (int k = 0; k < CH; k++) begin
          r_buf[k][r_wr_ptr]   <= w_x[k];
          r_sum[k]             <= w_sum_new[k];
          r_data[k*DW +: DW]   <= w_res[k];
        end
        r_wr_ptr <= r_wr_ptr + ONE_P;
        r_fill   <= w_fill_nxt;
        r_primed <= (w_fill_nxt == FULL);
        r_sat    <= w_sat;
      end
    end
  end

  assign data_o   = r_data;
  assign valid_o  = r_valid;
  assign primed_o = r_primed;
  assign sat_o    = r_sat;
endmodule

// File: tb/tb_moving_avg_dcr.sv
// Scoreboard bench: unit 0 uses default parameters, unit 1 uses DW=16, LOG2_DEPTH=1, CH=4.
module tb_moving_avg_dcr;
  typedef struct {
    logic [127:0] dat;
    logic [3:0]   sat;
    logic         primed;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn;
  logic        a_start, a_valid, a_clear, a_vo, a_po;
  logic [1:0]  a_mode, a_sat;
  logic [63:0] a_din, a_dout;
  logic        b_start, b_valid, b_clear, b_vo, b_po;
  logic [1:0]  b_mode;
  logic [3:0]  b_sat;
  logic [63:0] b_din, b_dout;

  moving_avg_dcr u_a (
    .clk(clk), .rst(rstn[0]), .start_i(a_start), .valid_i(a_valid), .clear_i(a_clear),
    .mode_i(a_mode), .data_i(a_din), .data_o(a_dout), .valid_o(a_vo), .primed_o(a_po), .sat_o(a_sat)
  );
  moving_avg_dcr #(.DW(16), .LOG2_DEPTH(1), .CH(4)) u_b (
    .clk(clk), .rst(rstn[1]), .start_i(b_start), .valid_i(b_valid), .clear_i(b_clear),
    .mode_i(b_mode), .data_i(b_din), .data_o(b_dout), .valid_o(b_vo), .primed_o(b_po), .sat_o(b_sat)
  );

  int    chk_cnt = 0;
  int    pass_cnt = 0;
  exp_t  q0[$];
  exp_t  q1[$];
  exp_t  last_e [2];
  longint hist [8][$];
  int    fillc [2];
  int    acc_cnt [2];
  int    vo_cnt [2];
  bit    mon_en = 1'b0;
  int    dw_of [2] = '{32, 16};
  int    l2_of [2] = '{7, 1};
  int    ch_of [2] = '{2, 4};

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
  endtask

  function automatic longint get_x(logic [63:0] d, int k, int dw);
    logic [63:0] t;
    longint v, full;
    t    = (d >> (k*dw)) & ((64'd1 << dw) - 64'd1);
    v    = longint'(t);
    full = longint'(64'd1 << dw);
    if (v >= full/2) v -= full;
    return v;
  endfunction

  function automatic longint floor_div(longint s, longint d);
    longint q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q -= 1;
    return q;
  endfunction

  // Reference: mean of the last DEPTH accepted samples (missing ones are zero), floored.
  function automatic exp_t model_accept(int u, logic [1:0] md, logic [63:0] d);
    exp_t   e;
    longint depth, lim, x, s, mean, r;
    int     idx;
    depth = longint'(1) << l2_of[u];
    lim   = longint'(1) << (dw_of[u]-1);
    e.dat = '0;
    e.sat = '0;
    for (int k = 0; k < ch_of[u]; k++) begin
      idx = u*4 + k;
      x = get_x(d, k, dw_of[u]);
      hist[idx].push_back(x);
      if (hist[idx].size() > depth) void'(hist[idx].pop_front());
      s = 0;
      for (int i = 0; i < hist[idx].size(); i++) s += hist[idx][i];
      mean = floor_div(s, depth);
      case (md)
        2'b00:   r = x;
        2'b10:   r = mean;
        default: r = x - mean;
      endcase
      if (md == 2'b01 || md == 2'b11) begin
        if (r > lim - 1) begin r = lim - 1; e.sat[k] = 1'b1; end
        else if (r < -lim) begin r = -lim; e.sat[k] = 1'b1; end
      end
      e.dat |= (128'(r) & ((128'd1 << dw_of[u]) - 128'd1)) << (k*dw_of[u]);
    end
    if (fillc[u] < depth) fillc[u]++;
    e.primed = (fillc[u] == depth);
    return e;
  endfunction

  task automatic model_clear(int u);
    for (int k = 0; k < 4; k++) hist[u*4+k].delete();
    fillc[u]         = 0;
    last_e[u].dat    = '0;
    last_e[u].sat    = '0;
    last_e[u].primed = 1'b0;
  endtask

  task automatic drive(int u, logic st, logic vl, logic cl, logic [1:0] md, logic [63:0] d);
    exp_t e;
    if (u == 0) begin
      a_start = st; a_valid = vl; a_clear = cl; a_mode = md; a_din = d; b_valid = 1'b0;
    end else begin
      b_start = st; b_valid = vl; b_clear = cl; b_mode = md; b_din = d; a_valid = 1'b0;
    end
    if (rstn[u] && st && vl && !cl) begin
      e = model_accept(u, md, d);
      acc_cnt[u]++;
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (cl || !rstn[u]) model_clear(u);
  endtask

  task automatic idle(int u);
    drive(u, 1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), {$urandom, $urandom});
  endtask

  task automatic rst_unit(int u);
    rstn[u] = 1'b0;
    drive(u, 1'b1, 1'b1, 1'b0, 2'b01, {$urandom, $urandom});
    rstn[u] = 1'b1;
  endtask

  function automatic logic [31:0] rs32();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [15:0] rs16();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic mon(int u, logic vo, logic [63:0] dout, logic [3:0] sat, logic po);
    exp_t e;
    if (vo) begin
      vo_cnt[u]++;
      if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
        chk($sformatf("u%0d_unexpected_valid", u), 128'd1, 128'd0);
      end else begin
        if (u == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("u%0d_data", u), dout, e.dat);
        chk($sformatf("u%0d_sat", u), sat, e.sat);
        chk($sformatf("u%0d_primed", u), po, e.primed);
        last_e[u] = e;
      end
    end else begin
      chk($sformatf("u%0d_hold_data", u), dout, last_e[u].dat);
      chk($sformatf("u%0d_hold_sat", u), sat, last_e[u].sat);
      chk($sformatf("u%0d_hold_primed", u), po, last_e[u].primed);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, a_vo, a_dout, {2'b00, a_sat}, a_po);
      mon(1, b_vo, b_dout, b_sat, b_po);
    end
  end

  logic [63:0] seq_d [150];
  logic [1:0]  seq_m [150];

  initial begin
    rstn = 2'b00;
    a_start = 0; a_valid = 0; a_clear = 0; a_mode = 0; a_din = 0;
    b_start = 0; b_valid = 0; b_clear = 0; b_mode = 0; b_din = 0;
    for (int u = 0; u < 2; u++) begin
      model_clear(u);
      acc_cnt[u] = 0;
      vo_cnt[u]  = 0;
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 2'b01, 64'h1234);
    drive(1, 1'b1, 1'b1, 1'b0, 2'b01, 64'h1234);
    chk("rst_a_data", a_dout, 0);
    chk("rst_a_valid", a_vo, 0);
    chk("rst_a_primed", a_po, 0);
    chk("rst_b_data", b_dout, 0);
    chk("rst_b_sat", b_sat, 0);
    rstn = 2'b11;
    idle(0);

    // Constant 1000 on ch0, DC-removed output decays to zero as the window fills.
    for (int n = 1; n <= 140; n++) begin
      drive(0, 1'b1, 1'b1, 1'b0, 2'b01, {32'd0, 32'd1000});
      if (n == 1)   chk("dc_first", a_dout[31:0], 32'd993);
      if (n == 127) chk("dc_primed_127", a_po, 0);
      if (n == 128) begin
        chk("dc_zero_128", a_dout[31:0], 0);
        chk("dc_primed_128", a_po, 1);
      end
    end

    // Mean mode step to -1000.
    for (int n = 1; n <= 140; n++) begin
      drive(0, 1'b1, 1'b1, 1'b0, 2'b10, {32'd0, 32'hFFFF_FC18});
      if (n == 1) chk("mean_step1", a_dout[31:0], 32'd984);
    end
    chk("mean_final", a_dout[31:0], 32'hFFFF_FC18);

    // Clear colliding with a sample mid-window.
    for (int n = 0; n < 10; n++) drive(0, 1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)), {rs32(), rs32()});
    drive(0, 1'b1, 1'b1, 1'b1, 2'b01, {rs32(), rs32()});
    chk("clr_valid", a_vo, 0);
    chk("clr_data", a_dout, 0);
    chk("clr_primed", a_po, 0);
    chk("clr_sat", a_sat, 0);
    drive(0, 1'b1, 1'b1, 1'b0, 2'b01, {32'd0, 32'd12345});
    chk("clr_next", a_dout[31:0], 32'd12249);
    chk("clr_next_vld", a_vo, 1);

    // Same sample sequence back-to-back and sparse.
    for (int i = 0; i < 150; i++) begin
      seq_d[i] = {rs32(), rs32()};
      seq_m[i] = 2'($urandom_range(0, 3));
    end
    drive(0, 1'b1, 1'b0, 1'b1, 2'b00, 64'd0);
    for (int i = 0; i < 150; i++) drive(0, 1'b1, 1'b1, 1'b0, seq_m[i], seq_d[i]);
    drive(0, 1'b1, 1'b0, 1'b1, 2'b00, 64'd0);
    for (int i = 0; i < 150; i++) begin
      idle(0);
      idle(0);
      if (i == 50)
        for (int j = 0; j < 10; j++) drive(0, 1'b0, 1'b1, 1'b0, 2'($urandom_range(0, 3)), {$urandom, $urandom});
      drive(0, 1'b1, 1'b1, 1'b0, seq_m[i], seq_d[i]);
    end

    // Random traffic on unit 0.
    for (int i = 0; i < 400; i++)
      drive(0, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0),
            2'($urandom_range(0, 3)), {rs32(), rs32()});
    idle(0);

    // Saturation on unit 1: primed at full negative, then full positive.
    drive(1, 1'b1, 1'b1, 1'b0, 2'b01, {48'd0, 16'h8000});
    drive(1, 1'b1, 1'b1, 1'b0, 2'b01, {48'd0, 16'h8000});
    chk("sat_pre", b_sat, 0);
    drive(1, 1'b1, 1'b1, 1'b0, 2'b01, {48'd0, 16'h7fff});
    chk("sat_data", b_dout[15:0], 16'h7fff);
    chk("sat_flag", b_sat[0], 1);
    drive(1, 1'b1, 1'b1, 1'b0, 2'b01, {48'd0, 16'h7fff});
    chk("sat_after", b_sat[0], 0);
    chk("sat_after_data", b_dout[15:0], 0);

    // Per-channel ramps with a reset pulse mid-stream.
    for (int n = 0; n < 20; n++) begin
      if (n == 10) begin
        rst_unit(1);
        drive(1, 1'b1, 1'b1, 1'b0, 2'b10, {16'd400, 16'd300, 16'd200, 16'd100});
        chk("ramp_restart", b_dout, {16'd200, 16'd150, 16'd100, 16'd50});
        chk("ramp_restart_primed", b_po, 0);
      end
      drive(1, 1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)),
            {16'(400 + n*12), 16'(300 + n*9), 16'(200 + n*6), 16'(100 + n*3)});
    end

    for (int i = 0; i < 400; i++)
      drive(1, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0),
            2'($urandom_range(0, 3)), {rs16(), rs16(), rs16(), rs16()});

    for (int i = 0; i < 3; i++) begin
      idle(0);
      idle(1);
    end
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("a_valid_count", vo_cnt[0], acc_cnt[0]);
    chk("b_valid_count", vo_cnt[1], acc_cnt[1]);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/moving_avg_dcr.md
MOVING_AVG_DCR -- requirements
Module: moving_avg_dcr

Interface
REQ-001 Parameter DW, default 32: sample width per channel, signed two's complement.
REQ-002 Parameter LOG2_DEPTH, default 7: window depth = 2**LOG2_DEPTH samples; legal range 1..10.
REQ-003 Parameter CH, default 2: independent channels (I/Q = 2), legal range 1..4.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 start_i  input  1  block enable; when low, no sample is accepted.
REQ-007 valid_i  input  1  input sample strobe; a sample is accepted when start_i & valid_i.
REQ-008 clear_i  input  1  synchronous flush of window and accumulators, without a full reset.
REQ-009 mode_i  input  2  output select: 00 bypass, 01 DC-removed (x - mean), 10 mean, 11 reserved (behaves as 01).
REQ-010 data_i  input  CH*DW  packed samples; channel k occupies bits [k*DW +: DW].
REQ-011 data_o  output  CH*DW  packed registered result, same packing as data_i.
REQ-012 valid_o  output  1  one-cycle pulse marking a new data_o.
REQ-013 primed_o  output  1  high once the window holds DEPTH accepted samples since the last reset or clear.
REQ-014 sat_o  output  CH  per-channel flag; high with valid_o when that channel saturated in the current output.

Function
REQ-015 Each channel SHALL keep a circular buffer of DEPTH entries, a write pointer shared by all channels, and a signed accumulator of DW+LOG2_DEPTH bits.
REQ-016 On acceptance in cycle t, per channel: sum_new = sum + x - buf[wr_ptr]; buf[wr_ptr] <= x; sum <= sum_new.
REQ-017 On acceptance, wr_ptr SHALL increment modulo DEPTH and wrap from DEPTH-1 to 0 with no gap.
REQ-018 mean SHALL equal sum_new arithmetically right-shifted by LOG2_DEPTH (floor toward minus infinity), and SHALL include the current sample.
REQ-019 dcr SHALL be computed at DW+1 bits as x - mean, then saturated to DW bits: values above 2**(DW-1)-1 clamp to that maximum, and values below -2**(DW-1) clamp to that minimum.
REQ-020 The selected result SHALL be registered into data_o at t+1 with valid_o = 1 for exactly that cycle, giving a latency of 1 cycle.
REQ-021 sat_o[k] SHALL be 1 only when mode_i selects dcr and channel k clamped; otherwise 0. sat_o SHALL update with data_o.
REQ-022 Without an acceptance, data_o SHALL hold its value, valid_o SHALL be 0, and the buffer, accumulators and pointers SHALL be unchanged.
REQ-023 mode_i SHALL be sampled in the acceptance cycle; changing it never disturbs the window state.
REQ-024 A fill counter (LOG2_DEPTH+1 bits) SHALL increment per acceptance and saturate at DEPTH; primed_o = (fill == DEPTH), registered, and asserts in the same cycle as valid_o for the DEPTH-th sample.
REQ-025 Before primed_o, empty slots count as zero (mean is a scaled partial sum). No correction is applied.
REQ-026 clear_i SHALL take priority over acceptance in the same cycle: the sample is dropped, and buffers, accumulators, wr_ptr, fill, primed_o, data_o and sat_o go to 0, with valid_o = 0 next cycle.
REQ-027 A buffer flush via clear_i or reset SHALL complete in one cycle. Buffers are register arrays, so a multi-cycle RAM-init FSM is not permitted.
REQ-028 Each accumulator SHALL never overflow, for any input sequence, because of its DW+LOG2_DEPTH width.
REQ-029 Valid strobes may be back-to-back every cycle or sparse; behaviour SHALL depend only on the sequence of accepted samples.

Reset
REQ-030 While rst = 0 at a clock edge: data_o = 0, valid_o = 0, primed_o = 0, sat_o = 0, wr_ptr = 0, fill = 0, all accumulators and buffer entries = 0.
REQ-031 Reset asserted mid-window SHALL discard all history. The first accepted sample after release SHALL behave as sample 1 of an empty window.
REQ-032 Samples presented while rst = 0 SHALL be ignored.

Verification
REQ-033 Defaults, mode 01, ch0 = 1000 constant for 128 accepts -> sample n output = 1000 - floor(1000*n/128); at n = 128 output 0 and primed_o rises with that valid_o; it stays 0 thereafter.
REQ-034 Mode 10, constant 1000 then step to -1000 after priming -> mean falls by floor steps of 2000/128 per accept, reaching -1000 after 128 further accepts; outputs stay within ±1 of the exact value.
REQ-035 Mode 01, DW = 16: primed with -32768, then input 32767 -> dcr exceeds range; data_o = 32767 and sat_o[0] = 1 for that sample only.
REQ-036 Valid_i asserted only every 3rd cycle, with start_i toggled low for 10 cycles -> results identical to the back-to-back run; valid_o count equals accept count.
REQ-037 clear_i and valid_i high in the same cycle, mid-window -> no valid_o; all outputs are 0; primed_o = 0; the next accept yields x - (x >>> 7).
REQ-038 LOG2_DEPTH = 1, CH = 4, distinct ramps per channel -> wrap at 2 verified; channels show no cross-talk; rst = 0 pulse mid-stream restarts all channels from empty.
